// File: rtl/mem_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_ctrl_pkg
// Description : Shared cache parameters, refill FSM encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_refill_ctrl_pkg;

    localparam int PID_WIDTH           = 4;
    localparam int DATA_WIDTH          = 32;
    localparam int ADDRESS_LENGTH      = 16;
    localparam int BYTE_CNT            = 2;

    localparam int MISSQ_DEPTH_DEFAULT = 8;
    // Dead cycles after each refill strobe before the next request may start
    localparam int GAP_CYCLES          = 2;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] c_st_idle = 3'd0;
    localparam logic [STATE_W-1:0] c_st_wr   = 3'd1;
    localparam logic [STATE_W-1:0] c_st_rd   = 3'd2;
    localparam logic [STATE_W-1:0] c_st_wait = 3'd3;
    localparam logic [STATE_W-1:0] c_st_resp = 3'd4;
    localparam logic [STATE_W-1:0] c_st_gap  = 3'd5;

    typedef struct packed {
        logic [PID_WIDTH-1:0]      pid;
        logic [ADDRESS_LENGTH-1:0] addr;
    } miss_entry_t;

    // Clear the byte-offset bits so the address points at the line start
    function automatic logic [ADDRESS_LENGTH-1:0] align_addr(
        input logic [ADDRESS_LENGTH-1:0] addr
    );
        return {addr[ADDRESS_LENGTH-1:BYTE_CNT], {BYTE_CNT{1'b0}}};
    endfunction

endpackage : mem_refill_ctrl_pkg
`default_nettype wire

// File: rtl/mem_refill_ctrl_miss_fifo.sv
`default_nettype none
// ============================================================================
// Module      : miss_fifo
// Description : Power-of-two FIFO holding outstanding cache misses. A push
//               while full is accepted only when a pop frees a slot the same
//               cycle. Full flag is a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module miss_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Qualify push/pop against occupancy and form the next count
    always_comb begin
        w_do_pop    = i_pop && (r_count != '0);
        w_do_push   = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);
        w_count_nxt = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end

    // Pointer, count and full-flag registers
    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the count
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = r_full;

endmodule : miss_fifo
`default_nettype wire

// File: rtl/mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_refill_ctrl
// Description : Cache refill controller. Queues misses, writes back a single
//               buffered dirty victim ahead of any read, fetches lines and
//               returns them to the cache as spaced one-cycle refill strobes.
//               Outputs are registered from next-state lookahead so a miss
//               on an idle block is refilled four cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_refill_ctrl
    import mem_refill_ctrl_pkg::*;
#(
    parameter int MISSQ_DEPTH = MISSQ_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic                      i_miss,
    input  logic [PID_WIDTH-1:0]      i_miss_pid,
    input  logic [ADDRESS_LENGTH-1:0] i_miss_addr,
    input  logic                      i_flush,
    input  logic [ADDRESS_LENGTH-1:0] i_flush_addr,
    input  logic [DATA_WIDTH-1:0]     i_flush_data,
    input  logic                      i_cache_busy,
    output logic                      o_miss_full,
    output logic                      o_rd_req,
    output logic [ADDRESS_LENGTH-1:0] o_rd_addr,
    input  logic                      i_rd_ack,
    input  logic                      i_rd_valid,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    output logic                      o_wr_req,
    output logic [ADDRESS_LENGTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0]     o_wr_data,
    input  logic                      i_wr_ack,
    output logic                      o_memEN,
    output logic [PID_WIDTH-1:0]      o_pid,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic [ADDRESS_LENGTH-1:0] o_addr
);

    localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [STATE_W-1:0]        r_state;
    logic [STATE_W-1:0]        w_state_nxt;
    logic [c_gap_w-1:0]        r_gap_cnt;
    logic                      r_fl_valid;
    logic [ADDRESS_LENGTH-1:0] r_fl_addr;
    logic [DATA_WIDTH-1:0]     r_fl_data;
    logic [DATA_WIDTH-1:0]     r_rd_data;
    miss_entry_t               w_head;
    miss_entry_t               w_miss_entry;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_fire;

    // Next-cycle values of the registered outputs
    logic                      w_rd_req_nxt;
    logic [ADDRESS_LENGTH-1:0] w_rd_addr_nxt;
    logic                      w_wr_req_nxt;
    logic [ADDRESS_LENGTH-1:0] w_wr_addr_nxt;
    logic [DATA_WIDTH-1:0]     w_wr_data_nxt;
    logic [PID_WIDTH-1:0]      w_pid_nxt;
    logic [DATA_WIDTH-1:0]     w_data_nxt;
    logic [ADDRESS_LENGTH-1:0] w_addr_nxt;

    assign w_miss_entry = '{pid: i_miss_pid, addr: i_miss_addr};
    // The head leaves the queue in the cycle its refill strobe is visible
    assign w_pop        = (r_state == c_st_resp) && o_memEN;

    miss_fifo #(
        .DEPTH (MISSQ_DEPTH),
        .WIDTH ($bits(miss_entry_t))
    ) u_miss_fifo (
        .clk     (clk),
        .RST     (RST),
        .i_push  (i_miss),
        .i_wdata (w_miss_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (o_miss_full)
    );

    // One-entry victim buffer; new flushes are dropped while it is occupied
    always_ff @(posedge clk) begin
        if (RST) begin
            r_fl_valid <= 1'b0;
            r_fl_addr  <= '0;
            r_fl_data  <= '0;
        end else if ((r_state == c_st_wr) && i_wr_ack) begin
            r_fl_valid <= 1'b0;
        end else if (i_flush && !r_fl_valid) begin
            r_fl_valid <= 1'b1;
            r_fl_addr  <= i_flush_addr;
            r_fl_data  <= i_flush_data;
        end
    end

    // Capture returning line data while waiting for it
    always_ff @(posedge clk) begin
        if (RST) begin
            r_rd_data <= '0;
        end else if ((r_state == c_st_wait) && i_rd_valid) begin
            r_rd_data <= i_rd_data;
        end
    end

    // State register and GAP dwell counter
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= c_st_idle;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= (r_state == c_st_gap) ? r_gap_cnt + 1'b1 : '0;
        end
    end

    // Next-state logic; a pending writeback always goes before a read
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_fl_valid)    w_state_nxt = c_st_wr;
                else if (!w_empty) w_state_nxt = c_st_rd;
            end
            c_st_wr:   if (i_wr_ack)   w_state_nxt = c_st_idle;
            c_st_rd:   if (i_rd_ack)   w_state_nxt = c_st_wait;
            c_st_wait: if (i_rd_valid) w_state_nxt = c_st_resp;
            c_st_resp: if (o_memEN)    w_state_nxt = c_st_gap;
            c_st_gap:  if (r_gap_cnt == c_gap_w'(GAP_CYCLES - 1))
                           w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Output decode from next state; the strobe fires on data arrival or
    // later in RESP, whenever the cache pipeline is free, for one cycle only
    always_comb begin
        w_fire = !i_cache_busy &&
                 (((r_state == c_st_wait) && i_rd_valid) ||
                  ((r_state == c_st_resp) && !o_memEN));

        w_rd_req_nxt  = (w_state_nxt == c_st_rd);
        w_rd_addr_nxt = w_rd_req_nxt ? align_addr(w_head.addr) : '0;
        w_wr_req_nxt  = (w_state_nxt == c_st_wr);
        w_wr_addr_nxt = w_wr_req_nxt ? r_fl_addr : '0;
        w_wr_data_nxt = w_wr_req_nxt ? r_fl_data : '0;

        w_pid_nxt  = '0;
        w_data_nxt = '0;
        w_addr_nxt = '0;
        if (w_fire) begin
            w_pid_nxt  = w_head.pid;
            w_data_nxt = (r_state == c_st_wait) ? i_rd_data : r_rd_data;
            w_addr_nxt = align_addr(w_head.addr);
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (RST) begin
            o_rd_req  <= 1'b0;
            o_rd_addr <= '0;
            o_wr_req  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_memEN   <= 1'b0;
            o_pid     <= '0;
            o_data    <= '0;
            o_addr    <= '0;
        end else begin
            o_rd_req  <= w_rd_req_nxt;
            o_rd_addr <= w_rd_addr_nxt;
            o_wr_req  <= w_wr_req_nxt;
            o_wr_addr <= w_wr_addr_nxt;
            o_wr_data <= w_wr_data_nxt;
            o_memEN   <= w_fire;
            o_pid     <= w_pid_nxt;
            o_data    <= w_data_nxt;
            o_addr    <= w_addr_nxt;
        end
    end

endmodule : mem_refill_ctrl
`default_nettype wire

// File: tb/tb_mem_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_refill_ctrl
// Description : Self-checking bench for mem_refill_ctrl: cycle tables for the
//               single-miss and flush-priority flows, plus sequences for the
//               full queue, backpressure, push/pop at full and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_refill_ctrl;
    import mem_refill_ctrl_pkg::*;

    localparam int AW = ADDRESS_LENGTH;
    localparam int DW = DATA_WIDTH;
    localparam int PW = PID_WIDTH;

    logic          clk = 1'b0;
    logic          RST;
    logic          i_miss;
    logic [PW-1:0] i_miss_pid;
    logic [AW-1:0] i_miss_addr;
    logic          i_flush;
    logic [AW-1:0] i_flush_addr;
    logic [DW-1:0] i_flush_data;
    logic          i_cache_busy;
    logic          o_miss_full;
    logic          o_rd_req;
    logic [AW-1:0] o_rd_addr;
    logic          i_rd_ack;
    logic          i_rd_valid;
    logic [DW-1:0] i_rd_data;
    logic          o_wr_req;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          i_wr_ack;
    logic          o_memEN;
    logic [PW-1:0] o_pid;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_addr;

    mem_refill_ctrl #(.MISSQ_DEPTH(8)) dut (
        .clk(clk), .RST(RST),
        .i_miss(i_miss), .i_miss_pid(i_miss_pid), .i_miss_addr(i_miss_addr),
        .i_flush(i_flush), .i_flush_addr(i_flush_addr), .i_flush_data(i_flush_data),
        .i_cache_busy(i_cache_busy), .o_miss_full(o_miss_full),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_ack(i_rd_ack),
        .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .i_wr_ack(i_wr_ack), .o_memEN(o_memEN), .o_pid(o_pid),
        .o_data(o_data), .o_addr(o_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_en  = -100;
    int serial   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          miss;
        logic [PW-1:0] mpid;
        logic [AW-1:0] maddr;
        logic          flush;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fdata;
        logic          rd_ack;
        logic          rd_valid;
        logic [DW-1:0] rd_data;
        logic          wr_ack;
        logic          e_full;
        logic          e_rd_req;
        logic [AW-1:0] e_rd_addr;
        logic          e_wr_req;
        logic [AW-1:0] e_wr_addr;
        logic [DW-1:0] e_wr_data;
        logic          e_mem_en;
        logic [PW-1:0] e_pid;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t        vecs[$];
    miss_entry_t mq[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {8'b0, o_miss_full, o_rd_req, o_rd_addr, o_wr_req, o_wr_addr,
                o_wr_data, o_memEN, o_pid, o_data, o_addr};
    endfunction

    function automatic logic [127:0] exp_of(input vec_t v);
        return {8'b0, v.e_full, v.e_rd_req, v.e_rd_addr, v.e_wr_req, v.e_wr_addr,
                v.e_wr_data, v.e_mem_en, v.e_pid, v.e_data, v.e_addr};
    endfunction

    // Refill strobes must never be closer than 3 cycles
    always @(negedge clk) begin
        if (o_memEN) begin
            n_checks++;
            if (cyc - last_en < 3) begin
                n_errors++;
                $display("FAIL spacing: got %0d cycles required >=3", cyc - last_en);
            end
            last_en = cyc;
        end
    end

    task automatic clear_inputs();
        i_miss = 0; i_miss_pid = 0; i_miss_addr = 0;
        i_flush = 0; i_flush_addr = 0; i_flush_data = 0;
        i_cache_busy = 0; i_rd_ack = 0; i_rd_valid = 0; i_rd_data = 0; i_wr_ack = 0;
    endtask

    // Push 8 misses back-to-back with memory stalled; model tracks acceptance
    task automatic fill8(input logic [AW-1:0] base, input logic [PW-1:0] pbase);
        for (int i = 0; i < 8; i++) begin
            i_miss      = 1'b1;
            i_miss_pid  = pbase + PW'(i);
            i_miss_addr = base + AW'(i * 16'h0104);
            if (mq.size() < 8) mq.push_back('{pid: i_miss_pid, addr: i_miss_addr});
            @(posedge clk); #1;
        end
        i_miss = 1'b0;
    endtask

    // Serve the queue head: ack the read, return data, optionally hold the
    // cache busy, then check the refill strobe against the model head
    task automatic serve(input int busy_cycles, input bit push_at_fire,
                         input logic [PW-1:0] ppid, input logic [AW-1:0] paddr);
        bit            got;
        miss_entry_t   e;
        logic [DW-1:0] d;
        e = (mq.size() > 0) ? mq[0] : '0;
        d = 32'hC0DE0000 | DW'(serial);
        serial++;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_rd_req) begin got = 1; break; end
        end
        check("rd_req_seen", 128'(got), 128'(1));
        check("rd_addr", 128'(o_rd_addr), 128'(align_addr(e.addr)));
        i_rd_ack = 1'b1;
        @(posedge clk); #1;
        i_rd_ack     = 1'b0;
        i_rd_valid   = 1'b1;
        i_rd_data    = d;
        i_cache_busy = (busy_cycles > 0);
        @(posedge clk); #1;
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
        for (int k = 1; k < busy_cycles; k++) begin
            @(negedge clk);
            check("busy_hold", 128'(o_memEN), 128'(0));
            @(posedge clk); #1;
        end
        i_cache_busy = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_memEN) begin got = 1; break; end
            @(posedge clk); #1;
        end
        check("mem_en_seen", 128'(got), 128'(1));
        check("refill", 128'({o_pid, o_data, o_addr}), 128'({e.pid, d, align_addr(e.addr)}));
        if (mq.size() > 0) void'(mq.pop_front());
        if (push_at_fire) begin
            i_miss      = 1'b1;
            i_miss_pid  = ppid;
            i_miss_addr = paddr;
            mq.push_back('{pid: ppid, addr: paddr});
        end
        @(posedge clk); #1;
        i_miss = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        bit   got;

        // ---- single miss (c0..c7) ----
        v = '0; v.miss = 1; v.mpid = 3; v.maddr = 16'h1234; vecs.push_back(v);
        v = '0; vecs.push_back(v);
        v = '0; v.rd_ack = 1; v.e_rd_req = 1; v.e_rd_addr = 16'h1234; vecs.push_back(v);
        v = '0; v.rd_valid = 1; v.rd_data = 32'h000000A5; vecs.push_back(v);
        v = '0; v.e_mem_en = 1; v.e_pid = 3; v.e_data = 32'h000000A5; v.e_addr = 16'h1234; vecs.push_back(v);
        v = '0; vecs.push_back(v);
        v = '0; vecs.push_back(v);
        v = '0; vecs.push_back(v);
        // ---- flush priority with second flush dropped (c0..c11) ----
        v = '0; v.flush = 1; v.faddr = 16'h0040; v.fdata = 32'hDEADBEEF;
        v.miss = 1; v.mpid = 1; v.maddr = 16'h0083; vecs.push_back(v);
        v = '0; v.flush = 1; v.faddr = 16'h0044; v.fdata = 32'h11111111; vecs.push_back(v);
        for (int i = 0; i < 3; i++) begin
            v = '0; v.wr_ack = (i == 2);
            v.e_wr_req = 1; v.e_wr_addr = 16'h0040; v.e_wr_data = 32'hDEADBEEF;
            vecs.push_back(v);
        end
        v = '0; vecs.push_back(v);
        v = '0; v.rd_ack = 1; v.e_rd_req = 1; v.e_rd_addr = 16'h0080; vecs.push_back(v);
        v = '0; v.rd_valid = 1; v.rd_data = 32'h00005A5A; vecs.push_back(v);
        v = '0; v.e_mem_en = 1; v.e_pid = 1; v.e_data = 32'h00005A5A; v.e_addr = 16'h0080; vecs.push_back(v);
        for (int i = 0; i < 3; i++) begin v = '0; vecs.push_back(v); end

        clear_inputs();
        RST = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 128'(0));
        @(posedge clk); #1;
        RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            i_miss = vecs[i].miss; i_miss_pid = vecs[i].mpid; i_miss_addr = vecs[i].maddr;
            i_flush = vecs[i].flush; i_flush_addr = vecs[i].faddr; i_flush_data = vecs[i].fdata;
            i_rd_ack = vecs[i].rd_ack; i_rd_valid = vecs[i].rd_valid;
            i_rd_data = vecs[i].rd_data; i_wr_ack = vecs[i].wr_ack;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), exp_of(vecs[i]));
            @(posedge clk); #1;
        end
        clear_inputs();

        // ---- full queue: 8 accepted, 9th dropped, 8 refills in order ----
        fill8(16'h1001, 4'd0);
        @(negedge clk);
        check("full_after_8", 128'(o_miss_full), 128'(1));
        @(posedge clk); #1;
        i_miss = 1'b1; i_miss_pid = 4'd9; i_miss_addr = 16'h2000;
        @(posedge clk); #1;
        i_miss = 1'b0;
        @(negedge clk);
        check("full_after_9th", 128'(o_miss_full), 128'(1));
        @(posedge clk); #1;
        serve(5, 1'b0, '0, '0);
        @(negedge clk);
        check("full_drops_after_pop", 128'(o_miss_full), 128'(0));
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) serve(0, 1'b0, '0, '0);
        got = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_rd_req || o_memEN) got = 1;
        end
        check("no_9th_refill", 128'(got), 128'(0));
        @(posedge clk); #1;

        // ---- simultaneous push and pop while full ----
        fill8(16'h3002, 4'd4);
        @(negedge clk);
        check("full_again", 128'(o_miss_full), 128'(1));
        @(posedge clk); #1;
        serve(0, 1'b1, 4'hE, 16'h4ABF);
        @(negedge clk);
        check("full_push_pop", 128'(o_miss_full), 128'(1));
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) serve(0, 1'b0, '0, '0);
        idle_wait();

        // ---- reset while waiting for read data ----
        i_miss = 1'b1; i_miss_pid = 4'd5; i_miss_addr = 16'h5555;
        @(posedge clk); #1;
        i_miss = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_rd_req) begin got = 1; break; end
        end
        check("rst_rd_req_seen", 128'(got), 128'(1));
        i_rd_ack = 1'b1;
        @(posedge clk); #1;
        i_rd_ack = 1'b0;
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        i_rd_valid = 1'b1; i_rd_data = 32'hBAD0BAD0;
        @(negedge clk);
        check("reset_mid_wait", outs(), 128'(0));
        @(posedge clk); #1;
        i_rd_valid = 1'b0;
        got = 0;
        repeat (15) begin
            @(negedge clk);
            if (o_memEN || o_rd_req) got = 1;
        end
        check("no_refill_after_reset", 128'(got), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    task automatic idle_wait();
        repeat (5) @(posedge clk);
        #1;
    endtask

endmodule : tb_mem_refill_ctrl
`default_nettype wire

// File: doc/mem_refill_ctrl.md
MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 SHALL have parameter MISSQ_DEPTH, default 8: miss-queue entries; power of two, at least 2. PID_WIDTH, DATA_WIDTH, ADDRESS_LENGTH and BYTE_CNT SHALL come from the shared cache parameter header.
REQ-002 SHALL use one clock `clk`; reset `RST` is synchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- RST  in  1  sync active-high reset.
- i_miss  in  1  cache miss strobe, one cycle per miss.
- i_miss_pid  in  PID_WIDTH  requesting PE ID.
- i_miss_addr  in  ADDRESS_LENGTH  miss address.
- i_flush  in  1  dirty-victim writeback strobe.
- i_flush_addr  in  ADDRESS_LENGTH  victim address.
- i_flush_data  in  DATA_WIDTH  victim data.
- i_cache_busy  in  1  cache MEM pipeline occupied (the cache's o_memEN).
- o_miss_full  out  1  miss queue full; upstream stalls PE issue.
- o_rd_req  out  1  memory read request, held until acked.
- o_rd_addr  out  ADDRESS_LENGTH  line-aligned read address.
- i_rd_ack  in  1  read request accepted.
- i_rd_valid  in  1  read data valid.
- i_rd_data  in  DATA_WIDTH  read data.
- o_wr_req  out  1  memory write request, held until acked.
- o_wr_addr  out  ADDRESS_LENGTH  write address.
- o_wr_data  out  DATA_WIDTH  write data.
- i_wr_ack  in  1  write accepted.
- o_memEN  out  1  one-cycle refill strobe into the cache (drives i_memEN).
- o_pid  out  PID_WIDTH  refill PID (drives PID_mem_in).
- o_data  out  DATA_WIDTH  refill data (drives Data_mem_in).
- o_addr  out  ADDRESS_LENGTH  refill address (drives Address_mem_in).

Function
REQ-004 SHALL keep a FIFO miss queue of {pid, addr}; i_miss with queue not full SHALL push; i_miss with queue full SHALL be ignored, queue unchanged.
REQ-005 SHALL assert o_miss_full exactly when the count equals MISSQ_DEPTH; push and pop in the same cycle SHALL both take effect and leave the count unchanged.
REQ-006 SHALL hold flushes in a one-entry buffer; i_flush while the buffer is occupied SHALL be ignored.
REQ-007 SHALL run an FSM with states IDLE, WR, RD, WAIT, RESP, GAP.
REQ-008 IDLE: a valid flush buffer -> WR; otherwise a non-empty queue -> RD. A flush SHALL always win over a read (write-before-read ordering).
REQ-009 WR: o_wr_req held with the buffer contents; on i_wr_ack, clear the buffer -> IDLE.
REQ-010 RD: o_rd_req held with the queue-head address, low BYTE_CNT bits zeroed; on i_rd_ack -> WAIT.
REQ-011 WAIT: on i_rd_valid, capture i_rd_data -> RESP. i_rd_valid in any other state SHALL be ignored.
REQ-012 RESP: while i_cache_busy is high, wait. When it is low, assert o_memEN for one cycle with head pid, captured data and aligned address, pop the queue -> GAP.
REQ-013 GAP: hold for 2 cycles -> IDLE, guaranteeing at least 3 cycles between o_memEN pulses.
REQ-014 o_pid, o_data, o_addr SHALL be 0 when o_memEN is low; o_*_addr and o_wr_data SHALL be 0 when their request is low.
REQ-015 Minimum latency (idle, empty, zero-wait memory) SHALL be 4 cycles: i_miss at cycle 0, o_rd_req at cycle 2, o_memEN at cycle 4.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 RST SHALL force IDLE, an empty queue, a cleared flush buffer, and all outputs to 0, including mid-transaction; in-flight memory requests are abandoned.

Structure
REQ-018 State encoding, MISSQ_DEPTH default and the GAP length constant SHALL live in the shared cache package/header; the miss queue SHALL be the sub-module miss_fifo.

Verification
REQ-019 Single miss: i_miss pid=3, addr=0x1234; i_rd_ack same cycle, i_rd_valid next cycle with data 0xA5 -> o_memEN at cycle 4 with o_pid=3, o_data=0xA5, o_addr line-aligned.
REQ-020 Flush priority: i_flush and i_miss in the same cycle -> o_wr_req precedes o_rd_req; no read is issued before i_wr_ack.
REQ-021 Full queue: 8 back-to-back misses with memory stalled -> o_miss_full=1; a 9th miss is dropped and exactly 8 refills return in FIFO order.
REQ-022 Spacing and backpressure: i_cache_busy high for 5 cycles while in RESP -> o_memEN delayed until busy drops; consecutive o_memEN pulses are at least 3 cycles apart.
REQ-023 Simultaneous push/pop at count=8 -> count stays 8 and o_miss_full stays 1.
REQ-024 Reset mid-WAIT -> all outputs 0 next cycle; a late i_rd_valid is ignored and no o_memEN is produced.
